// File: rtl/multicycle_control.sv
// Multi-cycle LEGv8 sequencer: steps one instruction at a time through fetch,
// decode, execute, memory and writeback, driving the shared-memory datapath.
module multicycle_control (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] instruction_i,
  input  logic        zero_i,
  input  logic        mem_ready_i,
  output logic        pc_write_o,
  output logic        ir_write_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic        mem_addr_sel_o,
  output logic [1:0]  imm_sel_o,
  output logic [1:0]  alu_src_a_o,
  output logic [1:0]  alu_src_b_o,
  output logic [1:0]  alu_op_o,
  output logic        pc_src_o,
  output logic        reg_write_o,
  output logic        mem_to_reg_o,
  output logic        reg2_loc_o,
  output logic [3:0]  state_o,
  output logic        illegal_o
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    R_EXEC    = 4'd6,
    R_WB      = 4'd7,
    BRANCH_CB = 4'd8,
    BRANCH_B  = 4'd9,
    HALT      = 4'd15
  } state_e;

  state_e state_q, state_d;
  logic   illegal_q, illegal_d;

  logic [10:0] opcode;
  logic isLdur, isStur, isRtype, isCbz, isB;
  logic unusedInstrBits;

  assign opcode  = instruction_i[31:21];
  assign isLdur  = (opcode == 11'b11111000010);
  assign isStur  = (opcode == 11'b11111000000);
  assign isRtype = (opcode == 11'b10001011000) || (opcode == 11'b11001011000) ||
                   (opcode == 11'b10001010000) || (opcode == 11'b10101010000);
  assign isCbz   = (instruction_i[31:24] == 8'b10110100);
  assign isB     = (instruction_i[31:26] == 6'b000101);
  assign unusedInstrBits = ^instruction_i[20:0];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH:     if (mem_ready_i) state_d = DECODE;
      DECODE: begin
        if (isLdur || isStur)  state_d = MEM_ADDR;
        else if (isRtype)      state_d = R_EXEC;
        else if (isCbz)        state_d = BRANCH_CB;
        else if (isB)          state_d = BRANCH_B;
        else                   state_d = HALT;
      end
      MEM_ADDR:  state_d = isLdur ? MEM_READ : MEM_WRITE;
      MEM_READ:  if (mem_ready_i) state_d = MEM_WB;
      MEM_WB:    state_d = FETCH;
      MEM_WRITE: if (mem_ready_i) state_d = FETCH;
      R_EXEC:    state_d = R_WB;
      R_WB:      state_d = FETCH;
      BRANCH_CB: state_d = FETCH;
      BRANCH_B:  state_d = FETCH;
      HALT:      state_d = HALT;
      default:   state_d = FETCH;
    endcase
    illegal_d = illegal_q || (state_d == HALT);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Strobes follow the state, with the FETCH handshake and CBZ pc_write
  // reacting to inputs in the same cycle; reset forces everything quiet.
  always_comb begin
    pc_write_o     = 1'b0;
    ir_write_o     = 1'b0;
    mem_read_o     = 1'b0;
    mem_write_o    = 1'b0;
    mem_addr_sel_o = 1'b0;
    imm_sel_o      = 2'b00;
    alu_src_a_o    = 2'b00;
    alu_src_b_o    = 2'b00;
    alu_op_o       = 2'b00;
    pc_src_o       = 1'b0;
    reg_write_o    = 1'b0;
    mem_to_reg_o   = 1'b0;
    reg2_loc_o     = 1'b0;
    if (!reset_i) begin
      if (isCbz && !isB)            imm_sel_o = 2'b10;
      else if (isLdur || isStur)    imm_sel_o = 2'b11;
      unique case (state_q)
        FETCH: begin
          mem_read_o = 1'b1;
          if (mem_ready_i) begin
            ir_write_o  = 1'b1;
            pc_write_o  = 1'b1;
            alu_src_b_o = 2'b01;
          end
        end
        DECODE: begin
          alu_src_a_o = 2'b01;
          alu_src_b_o = 2'b11;
        end
        MEM_ADDR: begin
          alu_src_a_o = 2'b10;
          alu_src_b_o = 2'b10;
          reg2_loc_o  = 1'b1;
        end
        MEM_READ: begin
          mem_read_o     = 1'b1;
          mem_addr_sel_o = 1'b1;
        end
        MEM_WB: begin
          reg_write_o  = 1'b1;
          mem_to_reg_o = 1'b1;
        end
        MEM_WRITE: begin
          mem_write_o    = 1'b1;
          mem_addr_sel_o = 1'b1;
          reg2_loc_o     = 1'b1;
        end
        R_EXEC: begin
          alu_src_a_o = 2'b10;
          alu_op_o    = 2'b10;
        end
        R_WB:      reg_write_o = 1'b1;
        BRANCH_CB: begin
          reg2_loc_o = 1'b1;
          alu_op_o   = 2'b01;
          pc_src_o   = 1'b1;
          pc_write_o = zero_i;
        end
        BRANCH_B: begin
          pc_src_o   = 1'b1;
          pc_write_o = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign state_o   = state_q;
  assign illegal_o = illegal_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: a per-instruction model expands each LEGv8
// instruction into its expected cycle-by-cycle states and strobes.
module tb_multicycle_control;

  logic        clk_i = 1'b0;
  logic        reset_i, zero_i, mem_ready_i;
  logic [31:0] instruction_i;
  logic        pc_write_o, ir_write_o, mem_read_o, mem_write_o, mem_addr_sel_o;
  logic [1:0]  imm_sel_o, alu_src_a_o, alu_src_b_o, alu_op_o;
  logic        pc_src_o, reg_write_o, mem_to_reg_o, reg2_loc_o, illegal_o;
  logic [3:0]  state_o;

  typedef struct packed {
    logic       pcWrite, irWrite, memRead, memWrite, memAddrSel;
    logic [1:0] immSel, aluSrcA, aluSrcB, aluOp;
    logic       pcSrc, regWrite, memToReg, reg2Loc;
  } outs_t;

  typedef struct {
    logic        rst;
    logic [31:0] instr;
    logic        ready;
    logic        zero;
    logic [3:0]  st;
    outs_t       outs;
    logic        ill;
  } cyc_t;

  typedef enum int {K_R, K_LD, K_ST, K_CB, K_B, K_ILL} kind_e;

  cyc_t        expQ[$];
  logic [31:0] curIr;
  int          checkCount = 0;
  int          passCount  = 0;
  int          stepNo     = 0;

  multicycle_control dut (
    .clk_i(clk_i), .reset_i(reset_i), .instruction_i(instruction_i),
    .zero_i(zero_i), .mem_ready_i(mem_ready_i),
    .pc_write_o(pc_write_o), .ir_write_o(ir_write_o), .mem_read_o(mem_read_o),
    .mem_write_o(mem_write_o), .mem_addr_sel_o(mem_addr_sel_o),
    .imm_sel_o(imm_sel_o), .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o),
    .alu_op_o(alu_op_o), .pc_src_o(pc_src_o), .reg_write_o(reg_write_o),
    .mem_to_reg_o(mem_to_reg_o), .reg2_loc_o(reg2_loc_o),
    .state_o(state_o), .illegal_o(illegal_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic kind_e classify(logic [31:0] i);
    logic [10:0] op = i[31:21];
    if (op == 11'h7C2) return K_LD;
    if (op == 11'h7C0) return K_ST;
    if (op == 11'h458 || op == 11'h658 || op == 11'h450 || op == 11'h550) return K_R;
    if (i[31:24] == 8'hB4) return K_CB;
    if (i[31:26] == 6'b000101) return K_B;
    return K_ILL;
  endfunction

  function automatic logic [1:0] immFor(logic [31:0] i);
    case (classify(i))
      K_CB:        return 2'b10;
      K_LD, K_ST:  return 2'b11;
      default:     return 2'b00;
    endcase
  endfunction

  function automatic logic rnd();
    return logic'($urandom_range(0, 1));
  endfunction

  task automatic pushCyc(logic rst, logic [3:0] st, logic rdy, logic z, outs_t o, logic ill);
    cyc_t c;
    c.rst = rst; c.instr = curIr; c.ready = rdy; c.zero = z;
    c.st = st; c.outs = o; c.ill = ill;
    expQ.push_back(c);
  endtask

  task automatic pushReset(logic [3:0] st, logic ill);
    pushCyc(1'b1, st, rnd(), rnd(), '0, ill);
  endtask

  // One instruction: fetch (with waits), decode, then the class-specific
  // tail. abortWrite stops a store in its first write cycle for a reset.
  task automatic modelInstr(logic [31:0] instr, logic z, int fetchWait,
                            int memWait, bit abortWrite, int haltCycles);
    outs_t o;
    logic [1:0] im;
    kind_e k = classify(instr);
    for (int w = 0; w < fetchWait; w++) begin
      o = '0; o.memRead = 1'b1; o.immSel = immFor(curIr);
      pushCyc(1'b0, 4'd0, 1'b0, rnd(), o, 1'b0);
    end
    o = '0; o.memRead = 1'b1; o.irWrite = 1'b1; o.pcWrite = 1'b1;
    o.aluSrcB = 2'b01; o.immSel = immFor(curIr);
    pushCyc(1'b0, 4'd0, 1'b1, rnd(), o, 1'b0);
    curIr = instr;
    im = immFor(instr);
    o = '0; o.immSel = im; o.aluSrcA = 2'b01; o.aluSrcB = 2'b11;
    pushCyc(1'b0, 4'd1, rnd(), rnd(), o, 1'b0);
    case (k)
      K_R: begin
        o = '0; o.immSel = im; o.aluSrcA = 2'b10; o.aluOp = 2'b10;
        pushCyc(1'b0, 4'd6, rnd(), rnd(), o, 1'b0);
        o = '0; o.immSel = im; o.regWrite = 1'b1;
        pushCyc(1'b0, 4'd7, rnd(), rnd(), o, 1'b0);
      end
      K_LD, K_ST: begin
        o = '0; o.immSel = im; o.aluSrcA = 2'b10; o.aluSrcB = 2'b10; o.reg2Loc = 1'b1;
        pushCyc(1'b0, 4'd2, rnd(), rnd(), o, 1'b0);
        if (k == K_LD) begin
          for (int w = 0; w <= memWait; w++) begin
            o = '0; o.immSel = im; o.memRead = 1'b1; o.memAddrSel = 1'b1;
            pushCyc(1'b0, 4'd3, (w == memWait), rnd(), o, 1'b0);
          end
          o = '0; o.immSel = im; o.regWrite = 1'b1; o.memToReg = 1'b1;
          pushCyc(1'b0, 4'd4, rnd(), rnd(), o, 1'b0);
        end else if (abortWrite) begin
          o = '0; o.immSel = im; o.memWrite = 1'b1; o.memAddrSel = 1'b1; o.reg2Loc = 1'b1;
          pushCyc(1'b0, 4'd5, 1'b0, rnd(), o, 1'b0);
          pushCyc(1'b1, 4'd5, 1'b0, rnd(), '0, 1'b0);
        end else begin
          for (int w = 0; w <= memWait; w++) begin
            o = '0; o.immSel = im; o.memWrite = 1'b1; o.memAddrSel = 1'b1; o.reg2Loc = 1'b1;
            pushCyc(1'b0, 4'd5, (w == memWait), rnd(), o, 1'b0);
          end
        end
      end
      K_CB: begin
        o = '0; o.immSel = im; o.reg2Loc = 1'b1; o.aluOp = 2'b01;
        o.pcSrc = 1'b1; o.pcWrite = z;
        pushCyc(1'b0, 4'd8, rnd(), z, o, 1'b0);
      end
      K_B: begin
        o = '0; o.immSel = im; o.pcSrc = 1'b1; o.pcWrite = 1'b1;
        pushCyc(1'b0, 4'd9, rnd(), rnd(), o, 1'b0);
      end
      default: begin
        for (int n = 0; n < haltCycles; n++) begin
          o = '0; o.immSel = im;
          pushCyc(1'b0, 4'd15, rnd(), rnd(), o, 1'b1);
        end
      end
    endcase
  endtask

  task automatic applyStimulus(cyc_t c);
    @(negedge clk_i);
    reset_i       = c.rst;
    instruction_i = c.instr;
    mem_ready_i   = c.ready;
    zero_i        = c.zero;
    #1;
    stepNo++;
  endtask

  task automatic checkOutput(string tag, logic [31:0] observed, logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s step %0d: observed %h expected %h", tag, stepNo, observed, expected);
  endtask

  task automatic runQueue();
    cyc_t  c;
    outs_t act;
    while (expQ.size() > 0) begin
      c = expQ.pop_front();
      applyStimulus(c);
      act = '{pc_write_o, ir_write_o, mem_read_o, mem_write_o, mem_addr_sel_o,
              imm_sel_o, alu_src_a_o, alu_src_b_o, alu_op_o,
              pc_src_o, reg_write_o, mem_to_reg_o, reg2_loc_o};
      checkOutput("state", 32'(state_o), 32'(c.st));
      checkOutput("strobes", 32'(act), 32'(c.outs));
      checkOutput("illegal", 32'(illegal_o), 32'(c.ill));
    end
  endtask

  initial begin
    logic [31:0] ins;
    kind_e k;
    reset_i = 1'b1; mem_ready_i = 1'b1; zero_i = 1'b0; instruction_i = 32'h0;
    curIr = 32'h0;

    repeat (3) pushCyc(1'b1, 4'd0, 1'b1, 1'b0, '0, 1'b0);
    runQueue();

    modelInstr(32'h8B020020, 1'b0, 0, 0, 0, 0); runQueue();
    modelInstr(32'hF8408020, 1'b0, 0, 2, 0, 0); runQueue();
    modelInstr(32'hB4000040, 1'b1, 0, 0, 0, 0); runQueue();
    modelInstr(32'hB4000040, 1'b0, 1, 0, 0, 0); runQueue();
    modelInstr(32'h14000010, 1'b0, 0, 0, 0, 0); runQueue();
    modelInstr(32'hF8000020, 1'b0, 0, 1, 0, 0); runQueue();

    for (int n = 0; n < 40; n++) begin
      k = kind_e'($urandom_range(0, 4));
      case (k)
        K_R: begin
          case ($urandom_range(0, 3))
            0: ins = {11'h458, 21'($urandom)};
            1: ins = {11'h658, 21'($urandom)};
            2: ins = {11'h450, 21'($urandom)};
            default: ins = {11'h550, 21'($urandom)};
          endcase
        end
        K_LD:    ins = {11'h7C2, 21'($urandom)};
        K_ST:    ins = {11'h7C0, 21'($urandom)};
        K_CB:    ins = {8'hB4, 24'($urandom)};
        default: ins = {6'b000101, 26'($urandom)};
      endcase
      modelInstr(ins, rnd(), $urandom_range(0, 2), $urandom_range(0, 3), 0, 0);
      runQueue();
    end

    // Store abandoned by reset mid-write, then a slow fetch must stay write-free.
    modelInstr(32'hF8000020, 1'b0, 0, 0, 1, 0);
    modelInstr(32'h8B020020, 1'b0, 2, 0, 0, 0);
    runQueue();

    modelInstr(32'hFFFFFFFF, 1'b0, 0, 0, 0, 10);
    pushReset(4'd15, 1'b1);
    modelInstr({6'b000000, 26'($urandom)}, 1'b0, 1, 0, 0, 4);
    pushReset(4'd15, 1'b1);
    modelInstr(32'h14000010, 1'b0, 0, 0, 0, 0);
    modelInstr(32'h8B020020, 1'b0, 0, 0, 0, 0);
    runQueue();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
